kf8255_handshake_peer: RTL and testbench
========================================

Name: kf8255_handshake_peer

Overview:
Peripheral-side partner for the KF8255 mode-1 strobed handshake. It sits on the device side of an 8255 port pair and plays two roles:
- Transmitter into an 8255 input port: it drives the data, pulses STB#, then waits for IBF to clear.
- Receiver from an 8255 output port: it watches OBF#, pulses ACK#, captures the data and waits for OBF# to return high.
Used to model/attach keyboards, printers and similar devices in the PC/XT platform and as a bench agent.

Parameters:
SYNC_STAGES, 2, synchroniser depth on ibf and obf_n (0 = sampled directly, same clock domain)
SETUP_CYCLES, 1, cycles pd_out is valid before stb_n falls (min 1)
STB_WIDTH, 2, cycles stb_n is held low (min 1)
ACK_WIDTH, 2, cycles ack_n is held low (min 1)
CAPTURE_OFFSET, 1, ack_n-low cycle (1..ACK_WIDTH) on which pd_in is captured

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
tx_valid  in  1  local side offers a byte to send
tx_data  in  8  byte to send
tx_ready  out  1  transmitter idle, accepts tx_data this cycle
pd_out  out  8  data driven toward 8255 input port
pd_oe  out  1  pd_out drive enable
stb_n  out  1  strobe to 8255 STB# (PC4/PC2)
ibf  in  1  8255 IBF (PC5/PC1)
obf_n  in  1  8255 OBF# (PC7/PC1)
ack_n  out  1  acknowledge to 8255 ACK# (PC6/PC2)
pd_in  in  8  data from 8255 output port (valid only while ack_n low)
rx_valid  out  1  captured byte available
rx_data  out  8  captured byte
rx_ready  in  1  local side consumes rx_data

Behaviour:
Reset (async, on reset_n low):
- tx_ready=0 during reset and 1 on the first cycle after release.
- pd_out=0, pd_oe=0, stb_n=1, ack_n=1, rx_valid=0, rx_data=0.
- All FSMs go to IDLE and the synchroniser flops are set to the inactive level (ibf=0, obf_n=1).
- A reset mid-transfer releases stb_n/ack_n immediately and the byte in flight is dropped.

TX FSM (states TX_IDLE, TX_SETUP, TX_STROBE, TX_HOLD, TX_WAIT):
- TX_IDLE: tx_ready=1. On tx_valid & tx_ready, register tx_data into pd_out, set pd_oe=1 and go to TX_SETUP.
- TX_SETUP: stay SETUP_CYCLES cycles, then go to TX_STROBE.
- TX_STROBE: stb_n=0 for exactly STB_WIDTH cycles, then go to TX_HOLD.
- TX_HOLD: one cycle with stb_n=1 and data still driven, then go to TX_WAIT.
- TX_WAIT: pd_oe=0. Wait for the synchronised ibf to be 0 (the CPU has read the port), then go to TX_IDLE.
- Accept-to-stb_n-fall latency is SETUP_CYCLES+1.
- If ibf is already 0 when TX_WAIT is entered, TX_WAIT takes one cycle.
- tx_valid outside TX_IDLE is ignored; the byte is held by the local side.
- There is no timeout; TX_WAIT waits forever.

RX FSM (states RX_IDLE, RX_ACK, RX_RELEASE):
- RX_IDLE: if the synchronised obf_n is 0 and the buffer is free (rx_valid=0, or rx_ready=1 this cycle), go to RX_ACK.
- If the buffer is full, ack_n stays high; this is deliberate back-pressure on the 8255.
- RX_ACK: ack_n=0 for exactly ACK_WIDTH cycles. pd_in is registered into rx_data on ack-low cycle CAPTURE_OFFSET; rx_valid rises the following cycle.
- RX_RELEASE: ack_n=1. Wait for the synchronised obf_n to be 1, then go to RX_IDLE. This prevents a double-ack of the same byte.
- rx_valid & rx_ready clears rx_valid. If a capture lands in the same cycle as a consume, the capture wins and rx_valid stays 1 with the new data.

General rules:
- The TX and RX channels are fully independent and may run simultaneously.
- Counters are sized $clog2(max(SETUP_CYCLES,STB_WIDTH,ACK_WIDTH)+1) bits, count down and saturate at 0. They never wrap.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package kf8255_peer_pkg: TX and RX state enum typedefs, and localparams for the inactive levels of the strobes (STB_IDLE=1, ACK_IDLE=1).
- One sub-module, kf8255_sync_bit: a SYNC_STAGES flop chain with a parameterised reset value, instantiated for ibf and obf_n.
- The two FSMs stay in the top module.

Test Plan:
- Reset, then tx_data=8'hA5 with tx_valid. Required: pd_out=A5 and pd_oe=1 on the next cycle; stb_n low for 2 cycles starting 2 cycles after accept; tx_ready=0 until ibf is driven 0.
- TX back-pressure: hold ibf=1 for 20 cycles after the strobe. Required: tx_ready stays 0 and a second tx_valid (8'h3C) is ignored. Drop ibf, and tx_ready=1 after SYNC_STAGES+1 cycles; 3C is then sent.
- RX: drive obf_n=0 and pd_in=8'h5A while ack_n is low. Required: ack_n low for exactly 2 cycles, then rx_valid=1 with rx_data=5A. No second ack while obf_n is 0; the next ack follows obf_n high→low.
- RX full: rx_ready=0 with rx_valid=1 and obf_n falling. Required: ack_n stays 1. Assert rx_ready: ack_n falls within SYNC_STAGES+1 cycles and the new byte 8'hC3 replaces the old one.
- Simultaneous: TX 8'h11 and RX 8'h22 start on the same cycle. Required: both complete independently with correct pulse widths.
- Pull reset_n low during TX_STROBE and RX_ACK. Required: stb_n=1, ack_n=1, pd_oe=0 and rx_valid=0 immediately (no clock edge needed); after release both FSMs are idle.

Source files
------------

// File: rtl/kf8255_handshake_peer_pkg.sv
// Shared types and constants for the KF8255 mode-1 handshake peer.
// Holds the TX/RX state encodings and the idle levels of the strobes.
package kf8255_peer_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP,
    TX_STROBE,
    TX_HOLD,
    TX_WAIT
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ACK,
    RX_RELEASE
  } rx_state_t;

  localparam logic STB_IDLE = 1'b1;
  localparam logic ACK_IDLE = 1'b1;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/kf8255_handshake_peer_if.sv
// Bundle of local-side and 8255-side signals around the handshake peer.
// The slave modport is the peer itself; master is whoever surrounds it.
interface kf8255_handshake_peer_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [7:0] pd_out;
  logic       pd_oe;
  logic       stb_n;
  logic       ibf;
  logic       obf_n;
  logic       ack_n;
  logic [7:0] pd_in;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    output tx_valid, tx_data, ibf, obf_n, pd_in, rx_ready,
    input  tx_ready, pd_out, pd_oe, stb_n, ack_n, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, ibf, obf_n, pd_in, rx_ready,
    output tx_ready, pd_out, pd_oe, stb_n, ack_n, rx_valid, rx_data
  );
endinterface

// File: rtl/kf8255_handshake_peer_sync.sv
// Single-bit flop-chain synchroniser with a configurable reset level.
// STAGES of 0 passes the input straight through for same-clock use.
module kf8255_sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  generate
    if (STAGES == 0) begin : gDirect
      assign o_q = i_d;
    end else begin : gChain
      logic [STAGES-1:0] r_chain;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_chain <= {STAGES{RESET_VAL}};
        end else begin
          r_chain[0] <= i_d;
          for (int i = 1; i < STAGES; i++) begin
            r_chain[i] <= r_chain[i-1];
          end
        end
      end

      assign o_q = r_chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/kf8255_handshake_peer.sv
// Device-side partner for the KF8255 mode-1 strobed handshake: an independent
// transmitter (STB#/IBF) and receiver (OBF#/ACK#), all outputs registered.
module kf8255_handshake_peer
  import kf8255_peer_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETUP_CYCLES   = 1,
  parameter int STB_WIDTH      = 2,
  parameter int ACK_WIDTH      = 2,
  parameter int CAPTURE_OFFSET = 1
) (
  input logic              clock,
  input logic              reset_n,
  kf8255_handshake_peer_if.slave bus
);

  localparam int CNT_MAX = maxOf3(SETUP_CYCLES, STB_WIDTH, ACK_WIDTH);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CAP_CNT = CW'(ACK_WIDTH - CAPTURE_OFFSET);

  logic w_ibfSync;
  logic w_obfSync;

  kf8255_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uIbfSync (
    .clock  (clock),
    .reset_n(reset_n),
    .i_d    (bus.ibf),
    .o_q    (w_ibfSync)
  );

  kf8255_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uObfSync (
    .clock  (clock),
    .reset_n(reset_n),
    .i_d    (bus.obf_n),
    .o_q    (w_obfSync)
  );

  tx_state_t     r_txState, w_txNext;
  logic [CW-1:0] r_txCnt, w_txCntNext;
  logic          r_txReady;
  logic [7:0]    r_pdOut;
  logic          r_pdOe;
  logic          r_stbN;

  // Counters are loaded with (length-1) on state entry and run down to 0.
  always_comb begin
    w_txNext    = r_txState;
    w_txCntNext = (r_txCnt != '0) ? r_txCnt - CW'(1) : '0;
    case (r_txState)
      TX_IDLE: begin
        if (bus.tx_valid && r_txReady) begin
          w_txNext    = TX_SETUP;
          w_txCntNext = CW'(SETUP_CYCLES - 1);
        end
      end
      TX_SETUP: begin
        if (r_txCnt == '0) begin
          w_txNext    = TX_STROBE;
          w_txCntNext = CW'(STB_WIDTH - 1);
        end
      end
      TX_STROBE: if (r_txCnt == '0) w_txNext = TX_HOLD;
      TX_HOLD:   w_txNext = TX_WAIT;
      TX_WAIT:   if (!w_ibfSync) w_txNext = TX_IDLE;
      default:   w_txNext = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_txState <= TX_IDLE;
      r_txCnt   <= '0;
      r_txReady <= 1'b0;
      r_pdOut   <= 8'h00;
      r_pdOe    <= 1'b0;
      r_stbN    <= STB_IDLE;
    end else begin
      r_txState <= w_txNext;
      r_txCnt   <= w_txCntNext;
      r_txReady <= (w_txNext == TX_IDLE);
      r_pdOe    <= (w_txNext == TX_SETUP) || (w_txNext == TX_STROBE) || (w_txNext == TX_HOLD);
      r_stbN    <= (w_txNext == TX_STROBE) ? ~STB_IDLE : STB_IDLE;
      if (r_txState == TX_IDLE && w_txNext == TX_SETUP) begin
        r_pdOut <= bus.tx_data;
      end
    end
  end

  rx_state_t     r_rxState, w_rxNext;
  logic [CW-1:0] r_rxCnt, w_rxCntNext;
  logic          r_ackN;
  logic          r_rxValid;
  logic [7:0]    r_rxData;
  logic          w_rxCapture;

  // A full buffer keeps ACK# high, holding the 8255 off until the byte is consumed.
  always_comb begin
    w_rxNext    = r_rxState;
    w_rxCntNext = (r_rxCnt != '0) ? r_rxCnt - CW'(1) : '0;
    case (r_rxState)
      RX_IDLE: begin
        if (!w_obfSync && (!r_rxValid || bus.rx_ready)) begin
          w_rxNext    = RX_ACK;
          w_rxCntNext = CW'(ACK_WIDTH - 1);
        end
      end
      RX_ACK:     if (r_rxCnt == '0) w_rxNext = RX_RELEASE;
      RX_RELEASE: if (w_obfSync) w_rxNext = RX_IDLE;
      default:    w_rxNext = RX_IDLE;
    endcase
  end

  assign w_rxCapture = (r_rxState == RX_ACK) && (r_rxCnt == CAP_CNT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rxState <= RX_IDLE;
      r_rxCnt   <= '0;
      r_ackN    <= ACK_IDLE;
      r_rxValid <= 1'b0;
      r_rxData  <= 8'h00;
    end else begin
      r_rxState <= w_rxNext;
      r_rxCnt   <= w_rxCntNext;
      r_ackN    <= (w_rxNext == RX_ACK) ? ~ACK_IDLE : ACK_IDLE;
      if (w_rxCapture) begin
        r_rxValid <= 1'b1;
        r_rxData  <= bus.pd_in;
      end else if (r_rxValid && bus.rx_ready) begin
        r_rxValid <= 1'b0;
      end
    end
  end

  assign bus.tx_ready = r_txReady;
  assign bus.pd_out   = r_pdOut;
  assign bus.pd_oe    = r_pdOe;
  assign bus.stb_n    = r_stbN;
  assign bus.ack_n    = r_ackN;
  assign bus.rx_valid = r_rxValid;
  assign bus.rx_data  = r_rxData;

endmodule

// File: tb/tb_kf8255_handshake_peer.sv
// Directed bench for kf8255_handshake_peer: a cycle table for the basic TX and
// RX handshakes, then hand-written back-pressure, overlap and reset sequences.
module tb_kf8255_handshake_peer;

  localparam int SYNC_STAGES = 2;
  localparam int NUM_VEC     = 25;

  logic clock;
  logic reset_n;

  kf8255_handshake_peer_if bus ();

  kf8255_handshake_peer #(
    .SYNC_STAGES   (SYNC_STAGES),
    .SETUP_CYCLES  (1),
    .STB_WIDTH     (2),
    .ACK_WIDTH     (2),
    .CAPTURE_OFFSET(1)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       txValid;
    logic [7:0] txData;
    logic       ibf;
    logic       obfN;
    logic [7:0] pdIn;
    logic       rxReady;
    logic       expTxReady;
    logic [7:0] expPdOut;
    logic       expPdOe;
    logic       expStbN;
    logic       expAckN;
    logic       expRxValid;
    logic [7:0] expRxData;
  } vector_t;

  vector_t vectors [NUM_VEC];

  int   passCount;
  int   checkCount;
  int   cycles;
  int   lowCount;
  int   badCount;
  int   stbLow, stbFalls, ackLow, ackFalls, pdBad;
  logic stbSeen, prevStb, prevAck;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vector_t v);
    bus.tx_valid = v.txValid;
    bus.tx_data  = v.txData;
    bus.ibf      = v.ibf;
    bus.obf_n    = v.obfN;
    bus.pd_in    = v.pdIn;
    bus.rx_ready = v.rxReady;
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return bus.stb_n;
      1:       return bus.ack_n;
      2:       return bus.pd_oe;
      default: return bus.tx_ready;
    endcase
  endfunction

  // Ticks until the selected output reaches level or the limit runs out.
  task automatic waitSignal(input int which, input logic level, input int limit, output int n);
    n = 0;
    while (pick(which) !== level && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    passCount  = 0;
    checkCount = 0;

    // txValid txData ibf obfN pdIn rxReady | txReady pdOut pdOe stbN ackN rxValid rxData
    vectors[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vectors[1]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    vectors[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vectors[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vectors[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    vectors[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vectors[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vectors[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vectors[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vectors[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vectors[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vectors[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vectors[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vectors[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A};
    vectors[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A};
    vectors[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A};
    vectors[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A};
    vectors[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A};
    vectors[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A};
    vectors[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
    vectors[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
    vectors[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
    vectors[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
    vectors[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77};
    vectors[24] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77};

    reset_n = 1'b0;
    applyStimulus(vectors[0]);
    tick();
    tick();
    checkOutput("reset.txReady", bus.tx_ready, 0);
    checkOutput("reset.pdOut",   bus.pd_out,   0);
    checkOutput("reset.pdOe",    bus.pd_oe,    0);
    checkOutput("reset.stbN",    bus.stb_n,    1);
    checkOutput("reset.ackN",    bus.ack_n,    1);
    checkOutput("reset.rxValid", bus.rx_valid, 0);
    checkOutput("reset.rxData",  bus.rx_data,  0);
    reset_n = 1'b1;

    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vectors[i]);
      tick();
      checkOutput($sformatf("vec%0d.txReady", i), bus.tx_ready, vectors[i].expTxReady);
      checkOutput($sformatf("vec%0d.pdOut",   i), bus.pd_out,   vectors[i].expPdOut);
      checkOutput($sformatf("vec%0d.pdOe",    i), bus.pd_oe,    vectors[i].expPdOe);
      checkOutput($sformatf("vec%0d.stbN",    i), bus.stb_n,    vectors[i].expStbN);
      checkOutput($sformatf("vec%0d.ackN",    i), bus.ack_n,    vectors[i].expAckN);
      checkOutput($sformatf("vec%0d.rxValid", i), bus.rx_valid, vectors[i].expRxValid);
      checkOutput($sformatf("vec%0d.rxData",  i), bus.rx_data,  vectors[i].expRxData);
    end

    // TX back-pressure: IBF held high must stall the transmitter and ignore a new offer.
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h96;
    tick();
    checkOutput("bp.acceptPdOut", bus.pd_out, 8'h96);
    bus.tx_valid = 1'b0;
    waitSignal(0, 1'b0, 10, cycles);
    checkOutput("bp.stbFall", bus.stb_n, 0);
    bus.ibf  = 1'b1;
    lowCount = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.stb_n === 1'b0) lowCount++;
      else break;
    end
    checkOutput("bp.stbWidth", lowCount, 2);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h3C;
    badCount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.tx_ready !== 1'b0 || bus.pd_out !== 8'h96 || bus.stb_n !== 1'b1) badCount++;
    end
    checkOutput("bp.stalledCycles", badCount, 0);
    bus.ibf = 1'b0;
    waitSignal(3, 1'b1, 10, cycles);
    checkOutput("bp.readyLatency", cycles, SYNC_STAGES + 1);
    tick();
    bus.tx_valid = 1'b0;
    checkOutput("bp.secondPdOut", bus.pd_out, 8'h3C);
    checkOutput("bp.secondPdOe",  bus.pd_oe,  1);
    waitSignal(0, 1'b0, 10, cycles);
    checkOutput("bp.secondStb", bus.stb_n, 0);
    bus.ibf = 1'b1;
    waitSignal(2, 1'b0, 10, cycles);
    checkOutput("bp.secondOeDrop", bus.pd_oe, 0);
    bus.ibf = 1'b0;
    waitSignal(3, 1'b1, 10, cycles);
    checkOutput("bp.secondDone", bus.tx_ready, 1);

    // RX full: buffer still holds 8'h77, so a falling OBF# must not be acknowledged.
    bus.obf_n    = 1'b0;
    bus.rx_ready = 1'b0;
    badCount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.ack_n !== 1'b1 || bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h77) badCount++;
    end
    checkOutput("full.ackHeld", badCount, 0);
    bus.rx_ready = 1'b1;
    waitSignal(1, 1'b0, SYNC_STAGES + 1, cycles);
    checkOutput("full.ackFall", bus.ack_n, 0);
    bus.rx_ready = 1'b0;
    checkOutput("full.oldConsumed", bus.rx_valid, 0);
    bus.pd_in = 8'hC3;
    lowCount  = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ack_n === 1'b0) lowCount++;
      else break;
    end
    checkOutput("full.ackWidth", lowCount, 2);
    bus.pd_in = 8'h00;
    bus.obf_n = 1'b1;
    checkOutput("full.rxValid", bus.rx_valid, 1);
    checkOutput("full.rxData",  bus.rx_data,  8'hC3);

    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    checkOutput("sim.preConsumed", bus.rx_valid, 0);
    repeat (3) tick();
    checkOutput("sim.preTxReady", bus.tx_ready, 1);

    // Simultaneous TX 8'h11 and RX 8'h22, with the bench playing the 8255.
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h11;
    bus.obf_n    = 1'b0;
    stbLow = 0; stbFalls = 0; ackLow = 0; ackFalls = 0; pdBad = 0;
    stbSeen = 1'b0; prevStb = 1'b1; prevAck = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      bus.tx_valid = 1'b0;
      if (bus.stb_n === 1'b0) begin
        stbLow++;
        if (prevStb) stbFalls++;
        if (bus.pd_out !== 8'h11) pdBad++;
        bus.ibf = 1'b1;
        stbSeen = 1'b1;
      end
      prevStb = bus.stb_n;
      if (stbSeen && bus.pd_oe === 1'b0) bus.ibf = 1'b0;
      if (bus.ack_n === 1'b0) begin
        ackLow++;
        if (prevAck) ackFalls++;
        bus.pd_in = 8'h22;
        bus.obf_n = 1'b1;
      end else begin
        bus.pd_in = 8'h00;
      end
      prevAck = bus.ack_n;
    end
    checkOutput("sim.stbWidth", stbLow,   2);
    checkOutput("sim.stbPulses", stbFalls, 1);
    checkOutput("sim.txData",   pdBad,    0);
    checkOutput("sim.ackWidth", ackLow,   2);
    checkOutput("sim.ackPulses", ackFalls, 1);
    checkOutput("sim.rxValid",  bus.rx_valid, 1);
    checkOutput("sim.rxData",   bus.rx_data,  8'h22);
    checkOutput("sim.txDone",   bus.tx_ready, 1);

    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;

    // Reset mid-transfer, with STB# and ACK# both low in their second cycle.
    bus.obf_n = 1'b0;
    tick();
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h44;
    tick();
    bus.tx_valid = 1'b0;
    tick();
    bus.pd_in = 8'h99;
    tick();
    checkOutput("rst.preStbLow",  bus.stb_n,    0);
    checkOutput("rst.preAckLow",  bus.ack_n,    0);
    checkOutput("rst.preRxValid", bus.rx_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst.stbN",    bus.stb_n,    1);
    checkOutput("rst.ackN",    bus.ack_n,    1);
    checkOutput("rst.pdOe",    bus.pd_oe,    0);
    checkOutput("rst.rxValid", bus.rx_valid, 0);
    checkOutput("rst.txReady", bus.tx_ready, 0);
    checkOutput("rst.rxData",  bus.rx_data,  0);
    checkOutput("rst.pdOut",   bus.pd_out,   0);
    bus.obf_n = 1'b1;
    bus.ibf   = 1'b0;
    bus.pd_in = 8'h00;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("rst.postTxReady", bus.tx_ready, 1);
    badCount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.stb_n !== 1'b1 || bus.ack_n !== 1'b1 || bus.rx_valid !== 1'b0 || bus.tx_ready !== 1'b1) badCount++;
    end
    checkOutput("rst.postIdle", badCount, 0);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h5F;
    tick();
    bus.tx_valid = 1'b0;
    checkOutput("rst.postAccept", bus.pd_out, 8'h5F);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
